// File: rtl/blink_pkg.sv
// Shared constants for the Blink RTC / timer-interrupt unit: I/O port map,
// status bit positions and a byte-lane helper.
package blink_pkg;

   localparam logic [7:0] ADDR_TACK      = 8'hB4;
   localparam logic [7:0] ADDR_TMK       = 8'hB5;
   localparam logic [7:0] ADDR_TIM0      = 8'hD0;
   localparam logic [7:0] ADDR_SNAP_TIM1 = 8'hD1;
   localparam logic [7:0] ADDR_SNAP_TIMM = 8'hD2;
   localparam logic [7:0] ADDR_SNAP_END  = 8'hD5;
   localparam logic [7:0] ADDR_ALM       = 8'hD8;

   localparam int ST_TICK = 0;
   localparam int ST_SEC  = 1;
   localparam int ST_MIN  = 2;
   localparam int ST_ALM0 = 3;

   function automatic logic [7:0] byte_sel(input logic [31:0] v, input logic [1:0] b);
      logic [7:0] r;
      case (b)
         2'd0:    r = v[7:0];
         2'd1:    r = v[15:8];
         2'd2:    r = v[23:16];
         default: r = v[31:24];
      endcase
      return r;
   endfunction

endpackage

// File: rtl/blink_stbit.sv
// One interrupt status bit: set by an event, cleared by write-1-to-clear;
// a set arriving in the same cycle as a clear wins so no event is lost.
module blink_stbit (
   input  logic clk,
   input  logic res_n,
   input  logic set_i,
   input  logic clr_i,
   output logic q_o
);

   logic q_q, q_d;

   always_comb begin
      q_d = q_q;
      if (set_i)
         q_d = 1'b1;
      else if (clr_i)
         q_d = 1'b0;
   end

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n)
         q_q <= 1'b0;
      else
         q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/blink_rtc.sv
// Blink real-time clock: divides ena into ticks/seconds/minutes, raises masked
// status interrupts (incl. minute alarms) and exposes everything on Z80 I/O.
module blink_rtc
   import blink_pkg::*;
#(
   parameter int TCK_DIV       = 49152,
   parameter int TICKS_PER_SEC = 200,
   parameter int MIN_W         = 21,
   parameter int NUM_ALM       = 2
) (
   input  logic       clk,
   input  logic       res_n,
   input  logic       ena,
   input  logic       restim,
   input  logic       reg_wr,
   input  logic       reg_rd,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       rd_hit,
   output logic       irq,
   output logic       t_1s,
   output logic       t_5ms
);

   localparam int S     = 3 + NUM_ALM;
   localparam int ALM_N = (NUM_ALM > 0) ? NUM_ALM : 1;
   localparam int TCK_W = $clog2(TCK_DIV);
   localparam int T0_W  = $clog2(TICKS_PER_SEC);

   localparam logic [TCK_W-1:0] TCK_MAX  = TCK_W'(TCK_DIV - 1);
   localparam logic [TCK_W-1:0] TCK_HALF = TCK_W'(TCK_DIV / 2);
   localparam logic [T0_W-1:0]  T0_MAX   = T0_W'(TICKS_PER_SEC - 1);
   localparam logic [T0_W-1:0]  T0_HALF  = T0_W'(TICKS_PER_SEC / 2);

   logic [TCK_W-1:0] tck_q, tck_d;
   logic [T0_W-1:0]  tim0_q, tim0_d;
   logic [5:0]       tim1_q, tim1_d;
   logic [MIN_W-1:0] timm_q, timm_d;
   logic [5:0]       snap_tim1_q, snap_tim1_d;
   logic [MIN_W-1:0] snap_timm_q, snap_timm_d;
   logic [MIN_W-1:0] alm_q [ALM_N];
   logic [MIN_W-1:0] alm_d [ALM_N];
   logic [S-1:0]     tmk_q, tmk_d;
   logic [S-1:0]     tsta, st_set, st_clr;
   logic [7:0]       rdata_q, rdata_d;
   logic             rd_hit_q, rd_hit_d;
   logic             t_1s_q, t_1s_d, t_5ms_q, t_5ms_d;
   logic             tick_ev, sec_ev, min_ev;

   logic       wr_tack, wr_tmk, rd_tim0, alm_hit;
   logic [7:0] alm_off;

   assign wr_tack = reg_wr && (addr == ADDR_TACK);
   assign wr_tmk  = reg_wr && (addr == ADDR_TMK);
   assign rd_tim0 = reg_rd && (addr == ADDR_TIM0);
   assign alm_off = addr - ADDR_ALM;
   assign alm_hit = (addr >= ADDR_ALM) && (alm_off < 8'(4 * NUM_ALM));

   // Counter cascade; restim overrides ena so held counters never emit events.
   always_comb begin
      tck_d   = tck_q;
      tim0_d  = tim0_q;
      tim1_d  = tim1_q;
      timm_d  = timm_q;
      tick_ev = 1'b0;
      sec_ev  = 1'b0;
      min_ev  = 1'b0;
      if (restim) begin
         tck_d  = '0;
         tim0_d = '0;
         tim1_d = '0;
         timm_d = '0;
      end else if (ena) begin
         if (tck_q == TCK_MAX) begin
            tck_d   = '0;
            tick_ev = 1'b1;
         end else begin
            tck_d = tck_q + 1'b1;
         end
         if (tick_ev) begin
            if (tim0_q == T0_MAX) begin
               tim0_d = '0;
               sec_ev = 1'b1;
            end else begin
               tim0_d = tim0_q + 1'b1;
            end
         end
         if (sec_ev) begin
            if (tim1_q == 6'd59) begin
               tim1_d = '0;
               min_ev = 1'b1;
            end else begin
               tim1_d = tim1_q + 1'b1;
            end
         end
         if (min_ev)
            timm_d = timm_q + 1'b1;
      end
   end

   always_comb begin
      st_set          = '0;
      st_set[ST_TICK] = tick_ev;
      st_set[ST_SEC]  = sec_ev;
      st_set[ST_MIN]  = min_ev;
      for (int k = 0; k < NUM_ALM; k++)
         st_set[ST_ALM0 + k] = min_ev && (timm_d == alm_q[k]);
      st_clr = wr_tack ? wdata[S-1:0] : '0;
   end

   // Snapshot is taken from the pre-edge counters so it pairs with the tim0 returned.
   always_comb begin
      snap_tim1_d = snap_tim1_q;
      snap_timm_d = snap_timm_q;
      if (restim) begin
         snap_tim1_d = '0;
         snap_timm_d = '0;
      end else if (rd_tim0) begin
         snap_tim1_d = tim1_q;
         snap_timm_d = timm_q;
      end
   end

   always_comb begin
      tmk_d = wr_tmk ? wdata[S-1:0] : tmk_q;
      for (int k = 0; k < ALM_N; k++)
         alm_d[k] = alm_q[k];
      for (int k = 0; k < NUM_ALM; k++) begin
         if (reg_wr && alm_hit && (alm_off[3:2] == 2'(k))) begin
            for (int i = 0; i < MIN_W; i++) begin
               if ((i / 8) == int'(alm_off[1:0]))
                  alm_d[k][i] = wdata[3'(i)];
            end
         end
      end
   end

   always_comb begin
      rdata_d  = rdata_q;
      rd_hit_d = 1'b0;
      if (reg_rd) begin
         if (addr == ADDR_TMK) begin
            rdata_d  = 8'(tsta);
            rd_hit_d = 1'b1;
         end else if (addr == ADDR_TIM0) begin
            rdata_d  = 8'(tim0_q);
            rd_hit_d = 1'b1;
         end else if (addr == ADDR_SNAP_TIM1) begin
            rdata_d  = 8'(snap_tim1_q);
            rd_hit_d = 1'b1;
         end else if ((addr >= ADDR_SNAP_TIMM) && (addr <= ADDR_SNAP_END)) begin
            rdata_d  = byte_sel(32'(snap_timm_q), addr[1:0] - 2'd2);
            rd_hit_d = 1'b1;
         end else if (alm_hit) begin
            rd_hit_d = 1'b1;
            for (int k = 0; k < NUM_ALM; k++) begin
               if (alm_off[3:2] == 2'(k))
                  rdata_d = byte_sel(32'(alm_q[k]), alm_off[1:0]);
            end
         end
      end
   end

   assign t_1s_d  = (tim0_d >= T0_HALF);
   assign t_5ms_d = (tck_d >= TCK_HALF);

   always_ff @(posedge clk or negedge res_n) begin
      if (!res_n) begin
         tck_q       <= '0;
         tim0_q      <= '0;
         tim1_q      <= '0;
         timm_q      <= '0;
         snap_tim1_q <= '0;
         snap_timm_q <= '0;
         tmk_q       <= '0;
         for (int k = 0; k < ALM_N; k++)
            alm_q[k] <= '0;
         rdata_q     <= '0;
         rd_hit_q    <= 1'b0;
         t_1s_q      <= 1'b0;
         t_5ms_q     <= 1'b0;
      end else begin
         tck_q       <= tck_d;
         tim0_q      <= tim0_d;
         tim1_q      <= tim1_d;
         timm_q      <= timm_d;
         snap_tim1_q <= snap_tim1_d;
         snap_timm_q <= snap_timm_d;
         tmk_q       <= tmk_d;
         for (int k = 0; k < ALM_N; k++)
            alm_q[k] <= alm_d[k];
         rdata_q     <= rdata_d;
         rd_hit_q    <= rd_hit_d;
         t_1s_q      <= t_1s_d;
         t_5ms_q     <= t_5ms_d;
      end
   end

   for (genvar i = 0; i < S; i++) begin : g_st
      blink_stbit u_stbit (
         .clk   (clk),
         .res_n (res_n),
         .set_i (st_set[i]),
         .clr_i (st_clr[i]),
         .q_o   (tsta[i])
      );
   end

   assign rdata  = rdata_q;
   assign rd_hit = rd_hit_q;
   assign irq    = |(tsta & tmk_q);
   assign t_1s   = t_1s_q;
   assign t_5ms  = t_5ms_q;

endmodule

// File: tb/tb_blink_rtc.sv
// Directed + random bench for blink_rtc; a time-based reference model derives
// every counter from the total count of accepted ena strobes.
module tb_blink_rtc;

   localparam int TCK_DIV = 4;
   localparam int TPS     = 5;
   localparam int MIN_W   = 8;
   localparam int NUM_ALM = 2;
   localparam int S       = 3 + NUM_ALM;

   logic       clk = 1'b0;
   logic       res_n = 1'b0;
   logic       ena = 1'b0, restim = 1'b0, reg_wr = 1'b0, reg_rd = 1'b0;
   logic [7:0] addr = 8'h00, wdata = 8'h00;
   logic [7:0] rdata;
   logic       rd_hit, irq, t_1s, t_5ms;

   blink_rtc #(
      .TCK_DIV       (TCK_DIV),
      .TICKS_PER_SEC (TPS),
      .MIN_W         (MIN_W),
      .NUM_ALM       (NUM_ALM)
   ) dut (
      .clk    (clk),
      .res_n  (res_n),
      .ena    (ena),
      .restim (restim),
      .reg_wr (reg_wr),
      .reg_rd (reg_rd),
      .addr   (addr),
      .wdata  (wdata),
      .rdata  (rdata),
      .rd_hit (rd_hit),
      .irq    (irq),
      .t_1s   (t_1s),
      .t_5ms  (t_5ms)
   );

   always #5 clk = ~clk;

   int cmp_cnt = 0;
   int fail_cnt = 0;

   // Reference model state: n = accepted ena strobes since last reset/restim.
   int         n = 0;
   logic [S-1:0] m_tsta = '0;
   logic [S-1:0] m_tmk = '0;
   logic [7:0] m_alm [NUM_ALM];
   logic [7:0] m_snap_tim1 = 8'h00;
   logic [7:0] m_snap_timm = 8'h00;
   logic [7:0] m_rdata = 8'h00;
   logic       m_rd_hit = 1'b0;

   function automatic int m_tck(input int c);  return c % TCK_DIV; endfunction
   function automatic int m_tim0(input int c); return (c / TCK_DIV) % TPS; endfunction
   function automatic int m_tim1(input int c); return (c / (TCK_DIV * TPS)) % 60; endfunction
   function automatic int m_timm(input int c); return (c / (TCK_DIV * TPS * 60)) % (1 << MIN_W); endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      cmp_cnt++;
      assert (obs === exp_v)
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      n = 0;
      m_tsta = '0;
      m_tmk = '0;
      for (int k = 0; k < NUM_ALM; k++) m_alm[k] = 8'h00;
      m_snap_tim1 = 8'h00;
      m_snap_timm = 8'h00;
      m_rdata = 8'h00;
      m_rd_hit = 1'b0;
   endtask

   task automatic model_edge(input bit e, input bit r, input bit w, input bit rd,
                             input logic [7:0] a, input logic [7:0] d);
      logic [S-1:0] set_v;
      logic [S-1:0] clr_v;
      int k, b;
      k = (int'(a) - 'hD8) / 4;
      b = (int'(a) - 'hD8) % 4;
      m_rd_hit = 1'b0;
      if (rd) begin
         if (a == 8'hB5) begin
            m_rdata = 8'(m_tsta); m_rd_hit = 1'b1;
         end else if (a == 8'hD0) begin
            m_rdata = 8'(m_tim0(n)); m_rd_hit = 1'b1;
            m_snap_tim1 = 8'(m_tim1(n));
            m_snap_timm = 8'(m_timm(n));
         end else if (a == 8'hD1) begin
            m_rdata = m_snap_tim1; m_rd_hit = 1'b1;
         end else if (a >= 8'hD2 && a <= 8'hD5) begin
            m_rdata = (a == 8'hD2) ? m_snap_timm : 8'h00; m_rd_hit = 1'b1;
         end else if (a >= 8'hD8 && a < 8'(8'hD8 + 4 * NUM_ALM)) begin
            m_rdata = (b == 0) ? m_alm[k] : 8'h00; m_rd_hit = 1'b1;
         end
      end
      set_v = '0;
      if (r) begin
         n = 0;
         m_snap_tim1 = 8'h00;
         m_snap_timm = 8'h00;
      end else if (e) begin
         n++;
         if (n % TCK_DIV == 0) set_v[0] = 1'b1;
         if (n % (TCK_DIV * TPS) == 0) set_v[1] = 1'b1;
         if (n % (TCK_DIV * TPS * 60) == 0) begin
            set_v[2] = 1'b1;
            for (int j = 0; j < NUM_ALM; j++)
               if (m_timm(n) == int'(m_alm[j])) set_v[3 + j] = 1'b1;
         end
      end
      clr_v = '0;
      if (w) begin
         if (a == 8'hB4) clr_v = d[S-1:0];
         if (a == 8'hB5) m_tmk = d[S-1:0];
         if (a >= 8'hD8 && a < 8'(8'hD8 + 4 * NUM_ALM) && b == 0) m_alm[k] = d;
      end
      m_tsta = (m_tsta & ~clr_v) | set_v;
   endtask

   task automatic check_outputs();
      check("rdata", 32'(rdata), 32'(m_rdata));
      check("rd_hit", 32'(rd_hit), 32'(m_rd_hit));
      check("irq", 32'(irq), 32'(|(m_tsta & m_tmk)));
      check("t_1s", 32'(t_1s), 32'(m_tim0(n) >= TPS / 2));
      check("t_5ms", 32'(t_5ms), 32'(m_tck(n) >= TCK_DIV / 2));
   endtask

   // Called at a negedge; drives one cycle, updates the model, checks at the next negedge.
   task automatic step(input bit e, input bit r, input bit w, input bit rd,
                       input logic [7:0] a, input logic [7:0] d);
      ena = e; restim = r; reg_wr = w; reg_rd = rd; addr = a; wdata = d;
      @(posedge clk);
      model_edge(e, r, w, rd, a, d);
      @(negedge clk);
      ena = 1'b0; restim = 1'b0; reg_wr = 1'b0; reg_rd = 1'b0;
      check_outputs();
   endtask

   task automatic rd_reg(input logic [7:0] a);
      step(1'b0, 1'b0, 1'b0, 1'b1, a, 8'h00);
   endtask

   task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
      step(1'b0, 1'b0, 1'b1, 1'b0, a, d);
   endtask

   task automatic run_to(input int target);
      int guard;
      guard = 0;
      while (n < target && guard < 20000) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         guard++;
      end
      if (n != target) begin
         cmp_cnt++;
         fail_cnt++;
         $error("FAIL run_to: reached %0d required %0d", n, target);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [7:0] addr_tab [16];
   logic [S-1:0] saved_tsta, saved_tmk;
   bit r_e, r_r, r_w, r_rd;
   int guard;

   initial begin
      addr_tab = '{8'hB4, 8'hB5, 8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5,
                   8'hD6, 8'hD8, 8'hD9, 8'hDC, 8'hDD, 8'hDF, 8'hE5, 8'h00};
      model_reset();

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_rdata", 32'(rdata), 32'h0);
      check("rst_rd_hit", 32'(rd_hit), 32'h0);
      check("rst_irq", 32'(irq), 32'h0);
      check("rst_t_1s", 32'(t_1s), 32'h0);
      check("rst_t_5ms", 32'(t_5ms), 32'h0);
      res_n = 1'b1;

      // First tick after 4 ena cycles
      repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      rd_reg(8'hB5);
      check("first_tick_tsta", 32'(rdata), 32'h01);
      rd_reg(8'hD0);
      check("first_tick_tim0", 32'(rdata), 32'h01);

      // Minute rollover with only the minute bit unmasked
      wr_reg(8'hB4, 8'h1F);
      wr_reg(8'hB5, 8'h04);
      run_to(1199);
      check("pre_min_irq", 32'(irq), 32'h0);
      run_to(1200);
      check("min_irq", 32'(irq), 32'h1);
      rd_reg(8'hB5);
      check("min_tsta", 32'(rdata), 32'h07);
      rd_reg(8'hD0);
      rd_reg(8'hD1);
      check("min_tim1", 32'(rdata), 32'h00);
      rd_reg(8'hD2);
      check("min_timm", 32'(rdata), 32'h01);

      // Alarm 0 at minute 3
      wr_reg(8'hD8, 8'h03);
      wr_reg(8'hB5, 8'h08);
      wr_reg(8'hB4, 8'h1F);
      run_to(3600);
      check("alm_irq", 32'(irq), 32'h1);
      rd_reg(8'hB5);
      check("alm_tsta", 32'(rdata), 32'h0F);
      rd_reg(8'hD8);
      check("alm_readback", 32'(rdata), 32'h03);
      wr_reg(8'hB4, 8'h08);
      check("alm_ack_irq", 32'(irq), 32'h0);
      run_to(4800);
      check("alm_norefire_irq", 32'(irq), 32'h0);
      rd_reg(8'hB5);
      check("alm_norefire_tsta", 32'(rdata), 32'h07);

      // Snapshot coherence: tim0=4, tim1=59, tick coincides with the D0 read
      run_to(5999);
      step(1'b1, 1'b0, 1'b0, 1'b1, 8'hD0, 8'h00);
      check("coh_tim0", 32'(rdata), 32'h04);
      rd_reg(8'hD1);
      check("coh_tim1", 32'(rdata), 32'h3B);
      rd_reg(8'hD2);
      check("coh_timm", 32'(rdata), 32'h04);

      // Set beats clear when TACK coincides with a tick
      wr_reg(8'hB4, 8'h1F);
      run_to(6003);
      step(1'b1, 1'b0, 1'b1, 1'b0, 8'hB4, 8'h01);
      rd_reg(8'hB5);
      check("set_wins", 32'(rdata), 32'h01);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         r_e  = ($urandom_range(0, 3) != 0);
         r_r  = ($urandom_range(0, 63) == 0);
         r_w  = ($urandom_range(0, 7) == 0);
         r_rd = ($urandom_range(0, 3) == 0);
         step(r_e, r_r, r_w, r_rd, addr_tab[$urandom_range(0, 15)], 8'($urandom));
      end

      // restim mid-count
      wr_reg(8'hB5, 8'h1F);
      guard = 0;
      while (!(m_tim0(n) >= TPS / 2 && m_tck(n) != 0) && guard < 40) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         guard++;
      end
      check("pre_restim_t1s", 32'(t_1s), 32'h1);
      saved_tsta = m_tsta;
      saved_tmk = m_tmk;
      repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      check("restim_t1s", 32'(t_1s), 32'h0);
      check("restim_t5ms", 32'(t_5ms), 32'h0);
      rd_reg(8'hD0);
      check("restim_tim0", 32'(rdata), 32'h00);
      rd_reg(8'hD1);
      check("restim_tim1", 32'(rdata), 32'h00);
      rd_reg(8'hD2);
      check("restim_timm", 32'(rdata), 32'h00);
      rd_reg(8'hB5);
      check("restim_tsta", 32'(rdata), 32'(saved_tsta));
      check("restim_irq", 32'(irq), 32'(|(saved_tsta & saved_tmk)));
      rd_reg(8'hE5);
      check("unmapped_rd_hit", 32'(rd_hit), 32'h0);
      check("unmapped_hold", 32'(rdata), 32'(saved_tsta));

      // Asynchronous reset in the middle of a cycle
      wr_reg(8'hB5, 8'h1F);
      repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      rd_reg(8'hD0);
      #2;
      res_n = 1'b0;
      #1;
      check("async_rdata", 32'(rdata), 32'h0);
      check("async_rd_hit", 32'(rd_hit), 32'h0);
      check("async_irq", 32'(irq), 32'h0);
      check("async_t_1s", 32'(t_1s), 32'h0);
      check("async_t_5ms", 32'(t_5ms), 32'h0);
      model_reset();
      @(negedge clk);
      res_n = 1'b1;
      repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      rd_reg(8'hB5);
      check("post_async_tsta", 32'(rdata), 32'h01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
      $finish;
   end

endmodule
